// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first serializer, NRZI, EOP.
// Define USB_TX_BITSTUFF_EN to enable bit stuffing; without it raw bits go straight to NRZI.
module usb_tx_encoder #(
    parameter int BITP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITP_W-1:0] bit_period,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_err,
    output logic              dplus_out,
    output logic              dminus_out,
    output logic              tx_oe
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_e;

    localparam logic [BITP_W-1:0] ONE = BITP_W'(1);
    localparam logic [BITP_W-1:0] TWO = BITP_W'(2);

    state_e            state_q, state_d;
    logic [BITP_W-1:0] per_q, per_d;
    logic [BITP_W-1:0] tmr_q, tmr_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              last_q, last_d;
    logic              hold_last_q, hold_last_d;
    logic              hold_full_q, hold_full_d;
    logic              line_q, line_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              dp_q, dp_d;
    logic              dm_q, dm_d;
    logic              oe_q, oe_d;

    logic accept;
    logic strobe;
    logic need_stuff;
    logic bit_start;
    logic raw_nxt;

    assign accept = tx_valid && ready_q;
    assign strobe = (tmr_q == per_q - ONE);

`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] ones_q, ones_d;
    logic       stuff_q, stuff_d;

    // ones_q counts consecutive raw ones up to and including the bit on the line
    assign need_stuff = (state_q == SYNC || state_q == DATA) &&
                        ones_q == 3'd6 && !stuff_q;

    always_comb begin
        ones_d  = ones_q;
        stuff_d = strobe ? 1'b0 : stuff_q;
        if (bit_start) begin
            stuff_d = need_stuff;
            ones_d  = raw_nxt ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q  <= 3'd0;
            stuff_q <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            stuff_q <= stuff_d;
        end
    end
`else
    assign need_stuff = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        tmr_d       = tmr_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        line_d      = line_q;
        err_d       = 1'b0;
        bit_start   = 1'b0;
        raw_nxt     = 1'b0;

        if (state_q != IDLE) begin
            tmr_d = strobe ? '0 : tmr_q + ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (accept || hold_full_q) begin
                    state_d   = SYNC;
                    per_d     = (bit_period < TWO) ? TWO : bit_period;
                    tmr_d     = '0;
                    bit_d     = 3'd0;
                    bit_start = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (strobe) begin
                    if (need_stuff) begin
                        bit_start = 1'b1;
                    end else if (bit_q != 3'd7) begin
                        bit_d     = bit_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_start = 1'b1;
                        raw_nxt   = (state_q == SYNC) ? (bit_q == 3'd6)
                                                      : shift_q[1];
                    end else if (state_q == SYNC ||
                                 (!last_q && hold_full_q)) begin
                        state_d     = DATA;
                        bit_d       = 3'd0;
                        shift_d     = hold_q;
                        last_d      = hold_last_q;
                        hold_full_d = 1'b0;
                        bit_start   = 1'b1;
                        raw_nxt     = hold_q[0];
                    end else begin
                        // a non-last byte with nothing queued behind it is an underrun
                        err_d   = !last_q;
                        state_d = EOP_SE0;
                        bit_d   = 3'd0;
                        line_d  = 1'b1;
                    end
                end
            end
            EOP_SE0: begin
                if (strobe) begin
                    if (bit_q == 3'd1) begin
                        state_d = EOP_J;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (strobe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bit_start) begin
            line_d = raw_nxt ? line_q : !line_q;
        end

        if (accept) begin
            hold_d      = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end

        dp_d    = (state_d == EOP_SE0) ? 1'b0 : line_d;
        dm_d    = (state_d == EOP_SE0) ? 1'b0 : !line_d;
        oe_d    = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        ready_d = !hold_full_d && (state_d inside {IDLE, SYNC, DATA});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            per_q       <= TWO;
            tmr_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            last_q      <= 1'b0;
            hold_q      <= 8'h00;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            line_q      <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            line_q      <= line_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            dp_q        <= dp_d;
            dm_q        <= dm_d;
            oe_q        <= oe_d;
        end
    end

    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign tx_err     = err_q;
    assign dplus_out  = dp_q;
    assign dminus_out = dm_q;
    assign tx_oe      = oe_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed testbench for usb_tx_encoder: line symbols per bit, packet length,
// underrun pulse, mid-packet reset and bit-period latching.
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bit_period = 8'd8;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, tx_busy, tx_err;
    logic       dplus_out, dminus_out, tx_oe;

    int n_chk = 0;
    int n_err = 0;

    logic [127:0] cap;
    int nb, busy_n, err_n, err_at, rdy_eop, oe_bad;
    logic cap_to, drv_to;

    usb_tx_encoder #(.BITP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_period (bit_period),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_err     (tx_err),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_oe      (tx_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // J = {dp,dm} 10, K = 01, S = SE0 00; symbol i sits in bits [2i+1:2i]
    function automatic logic [127:0] syms(input string s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++)
            r[2*i +: 2] = (s[i] == "J") ? 2'b10 :
                          (s[i] == "K") ? 2'b01 : 2'b00;
        return r;
    endfunction

    task automatic drive(input int bp, input int n, input logic [23:0] d,
                         input logic lst, input int bp2);
        int w;
        drv_to = 1'b0;
        @(negedge clk);
        bit_period = 8'(bp);
        for (int i = 0; i < n; i++) begin
            tx_data  = d[8*i +: 8];
            tx_last  = lst && (i == n - 1);
            tx_valid = 1'b1;
            w = 0;
            while (!tx_ready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (w >= 500) drv_to = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        tx_valid   = 1'b0;
        tx_last    = 1'b0;
        bit_period = 8'(bp2);
    endtask

    task automatic capture(input int p);
        int idx, w;
        cap = '0;
        nb = 0;
        err_n = 0;
        err_at = -1;
        rdy_eop = 0;
        oe_bad = 0;
        cap_to = 1'b0;
        w = 0;
        @(negedge clk);
        while (!tx_busy && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) cap_to = 1'b1;
        idx = 0;
        while (tx_busy && idx < 2000) begin
            if (idx % p == p / 2 && nb < 64) begin
                cap[2*nb +: 2] = {dplus_out, dminus_out};
                nb++;
            end
            if (tx_err) begin
                err_n++;
                if (err_at < 0) err_at = idx;
            end
            if (tx_ready && !dplus_out && !dminus_out) rdy_eop++;
            if (tx_oe != tx_busy) oe_bad++;
            @(negedge clk);
            idx++;
        end
        if (idx >= 2000) cap_to = 1'b1;
        busy_n = idx;
    endtask

    task automatic run(input string tag, input int bp, input int p,
                       input int n, input logic [23:0] d, input logic lst,
                       input int bp2, input string exp_s,
                       input int exp_busy, input int exp_err);
        fork
            drive(bp, n, d, lst, bp2);
            capture(p);
        join
        chk({tag, "_timeout"}, {drv_to, cap_to}, 2'b00);
        chk({tag, "_sym"}, cap, syms(exp_s));
        chk({tag, "_nbits"}, nb, exp_s.len());
        chk({tag, "_busy"}, busy_n, exp_busy);
        chk({tag, "_err"}, err_n, exp_err);
        chk({tag, "_rdy_eop"}, rdy_eop, 0);
        chk({tag, "_oe"}, oe_bad, 0);
        chk({tag, "_idle"}, {tx_oe, dplus_out, dminus_out}, 3'b010);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_vals", {dplus_out, dminus_out, tx_oe, tx_busy, tx_err, tx_ready},
            6'b100000);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_rise", tx_ready, 1'b1);

        run("a5_p8", 8, 8, 1, 24'h0000A5, 1'b1, 8,
            {"KJKJKJKK", "KJJKJJKK", "SSJ"}, 152, 0);

`ifdef USB_TX_BITSTUFF_EN
        run("ff_p4", 4, 4, 1, 24'h0000FF, 1'b1, 4,
            {"KJKJKJKK", "KKKKK", "JJJJ", "SSJ"}, 80, 0);
`else
        run("ff_p4", 4, 4, 1, 24'h0000FF, 1'b1, 4,
            {"KJKJKJKK", "KKKKKKKK", "SSJ"}, 76, 0);
`endif

        run("three_p4", 4, 4, 3, 24'h563412, 1'b1, 4,
            {"KJKJKJKK", "JJKJJKJK", "JKKJJJKJ", "KKKJJKKJ", "SSJ"}, 140, 0);

        run("underrun", 4, 4, 1, 24'h000000, 1'b0, 4,
            {"KJKJKJKK", "JKJKJKJK", "SSJ"}, 76, 1);
        chk("underrun_at", err_at, 64);

        @(negedge clk);
        bit_period = 8'd6;
        tx_data    = 8'h0F;
        tx_last    = 1'b0;
        tx_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (68) @(negedge clk);
        chk("pre_rst_busy", {tx_busy, tx_oe}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {dplus_out, dminus_out, tx_oe, tx_busy, tx_err, tx_ready},
            6'b100000);
        @(negedge clk);
        chk("rst_mid_ready", tx_ready, 1'b1);

        run("after_rst", 6, 6, 1, 24'h0000A5, 1'b1, 6,
            {"KJKJKJKK", "KJJKJJKK", "SSJ"}, 114, 0);

        run("bp1_chg", 1, 2, 1, 24'h0000A5, 1'b1, 9,
            {"KJKJKJKK", "KJJKJJKK", "SSJ"}, 38, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
